// File: rtl/irtifa_birlestirici.sv
// irtifa_birlestirici: pairs GNSS and altimeter altitude samples, rejects
// pairs that disagree by more than MAX_FARK, and smooths agreeing pairs
// through a 2^ORT_LOG2-deep moving average.
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   gnss_i              GNSS altitude sample (unsigned)
//   gnss_gecerli_i      one-cycle strobe, gnss_i valid
//   altimetre_i         altimeter altitude sample (unsigned)
//   altimetre_gecerli_i one-cycle strobe, altimetre_i valid
//   irtifa_o            fused, averaged altitude, held between updates
//   irtifa_gecerli_o    one-cycle pulse when irtifa_o updates
//   sensor_hata_o       sticky disagreement fault (exit only via reset)
//   durum_o             FSM state: 0 TOPLA, 1 KARSILASTIR, 2 ORTALA, 3 HATA
module irtifa_birlestirici #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAX_FARK   = 10,
  parameter int unsigned ORT_LOG2   = 2,
  parameter int unsigned HATA_ESIGI = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] gnss_i,
  input  logic              gnss_gecerli_i,
  input  logic [DATA_W-1:0] altimetre_i,
  input  logic              altimetre_gecerli_i,
  output logic [DATA_W-1:0] irtifa_o,
  output logic              irtifa_gecerli_o,
  output logic              sensor_hata_o,
  output logic [1:0]        durum_o
);

  typedef enum logic [1:0] {
    TOPLA       = 2'd0,
    KARSILASTIR = 2'd1,
    ORTALA      = 2'd2,
    HATA        = 2'd3
  } durum_t;

  localparam int unsigned PENCERE = 1 << ORT_LOG2;
  localparam int unsigned SAY_W   = $clog2(HATA_ESIGI + 1);
  localparam int unsigned TOP_W   = DATA_W + ORT_LOG2;
  localparam logic [ORT_LOG2:0] DOLU = (ORT_LOG2 + 1)'(PENCERE);

  durum_t              durum_q, durum_d;
  logic [DATA_W-1:0]   g_q, g_d, a_q, a_d;
  logic                g_bek_q, g_bek_d, a_bek_q, a_bek_d;
  logic [DATA_W-1:0]   pencere_q [PENCERE];
  logic [DATA_W-1:0]   pencere_d [PENCERE];
  logic [ORT_LOG2:0]   dolu_q, dolu_d;
  logic [SAY_W-1:0]    say_q, say_d;
  logic [DATA_W-1:0]   irtifa_q, irtifa_d;
  logic                gecerli_q, gecerli_d;

  logic [DATA_W:0]     fark;
  logic [DATA_W-1:0]   ort;
  logic [TOP_W-1:0]    toplam;

  // Pair arithmetic is done one bit wider so |g-a| and g+a never wrap.
  always_comb begin
    if (g_q >= a_q) fark = {1'b0, g_q} - {1'b0, a_q};
    else            fark = {1'b0, a_q} - {1'b0, g_q};
    ort    = DATA_W'(({1'b0, g_q} + {1'b0, a_q}) >> 1);
    toplam = '0;
    for (int unsigned i = 0; i < PENCERE; i++) begin
      toplam = toplam + TOP_W'(pencere_q[i]);
    end
  end

  always_comb begin
    durum_d   = durum_q;
    g_d       = g_q;
    a_d       = a_q;
    g_bek_d   = g_bek_q;
    a_bek_d   = a_bek_q;
    pencere_d = pencere_q;
    dolu_d    = dolu_q;
    say_d     = say_q;
    irtifa_d  = irtifa_q;
    gecerli_d = 1'b0;

    unique case (durum_q)
      TOPLA: begin
        if (g_bek_q && a_bek_q) durum_d = KARSILASTIR;
      end
      KARSILASTIR: begin
        g_bek_d = 1'b0;
        a_bek_d = 1'b0;
        if (fark <= (DATA_W + 1)'(MAX_FARK)) begin
          pencere_d[0] = ort;
          for (int unsigned i = 1; i < PENCERE; i++) begin
            pencere_d[i] = pencere_q[i-1];
          end
          if (dolu_q != DOLU) dolu_d = dolu_q + 1'b1;
          say_d   = '0;
          durum_d = ORTALA;
        end else begin
          say_d = say_q + 1'b1;
          if (say_d == SAY_W'(HATA_ESIGI)) durum_d = HATA;
          else                             durum_d = TOPLA;
        end
      end
      ORTALA: begin
        if (dolu_q == DOLU) begin
          irtifa_d  = DATA_W'(toplam >> ORT_LOG2);
          gecerli_d = 1'b1;
        end
        durum_d = TOPLA;
      end
      HATA: begin
        durum_d = HATA;
      end
      default: durum_d = TOPLA;
    endcase

    // Capture runs after the state logic so a strobe on the clearing edge
    // re-sets its pending flag and keeps the new sample.
    if (gnss_gecerli_i) begin
      g_d     = gnss_i;
      g_bek_d = 1'b1;
    end
    if (altimetre_gecerli_i) begin
      a_d     = altimetre_i;
      a_bek_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q   <= TOPLA;
      g_q       <= '0;
      a_q       <= '0;
      g_bek_q   <= 1'b0;
      a_bek_q   <= 1'b0;
      for (int unsigned i = 0; i < PENCERE; i++) pencere_q[i] <= '0;
      dolu_q    <= '0;
      say_q     <= '0;
      irtifa_q  <= '0;
      gecerli_q <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      g_q       <= g_d;
      a_q       <= a_d;
      g_bek_q   <= g_bek_d;
      a_bek_q   <= a_bek_d;
      pencere_q <= pencere_d;
      dolu_q    <= dolu_d;
      say_q     <= say_d;
      irtifa_q  <= irtifa_d;
      gecerli_q <= gecerli_d;
    end
  end

  assign irtifa_o         = irtifa_q;
  assign irtifa_gecerli_o = gecerli_q;
  assign sensor_hata_o    = (durum_q == HATA);
  assign durum_o          = durum_q;

endmodule

// File: tb/tb_irtifa_birlestirici.sv
module tb_irtifa_birlestirici;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] gnss, alt;
  logic        gs, as;
  logic [15:0] irtifa;
  logic        gecerli, hata;
  logic [1:0]  durum;

  irtifa_birlestirici #(
    .DATA_W(16), .MAX_FARK(10), .ORT_LOG2(2), .HATA_ESIGI(3)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .gnss_i              (gnss),
    .gnss_gecerli_i      (gs),
    .altimetre_i         (alt),
    .altimetre_gecerli_i (as),
    .irtifa_o            (irtifa),
    .irtifa_gecerli_o    (gecerli),
    .sensor_hata_o       (hata),
    .durum_o             (durum)
  );

  always #5 clk = ~clk;

  int toplam_say = 0;
  int hatali     = 0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    toplam_say++;
    if (gozlenen !== beklenen) begin
      hatali++;
      $display("FAIL %s: gozlenen=%0d beklenen=%0d", etiket, gozlenen, beklenen);
    end
  endtask

  // Reference model: latest samples, pending flags, window as a queue of
  // accepted pair means, consecutive-reject count, fault flag.
  int m_g, m_a;
  bit m_gp, m_ap;
  int pen[$];
  int miss;
  bit fault;
  int m_irt;

  task automatic model_reset();
    pen.delete();
    miss = 0; fault = 0; m_irt = 0; m_gp = 0; m_ap = 0; m_g = 0; m_a = 0;
  endtask

  // Called at a negedge. Strobes the chosen sensors for one cycle and, if a
  // pair is complete, follows it through edges k+1..k+4.
  task automatic surec(input bit ge, input bit ae, input int g, input int a,
                       input bit coll, input int coll_g, input bit rst_mid);
    int  fark, ort, sum, exp_d2;
    bit  pulse;
    gs = ge; as = ae;
    if (ge) gnss = 16'(g);
    if (ae) alt  = 16'(a);
    @(negedge clk);                       // edge k has passed
    gs = 0; as = 0;
    if (ge) begin m_g = g; m_gp = 1; end
    if (ae) begin m_a = a; m_ap = 1; end
    if (!(m_gp && m_ap)) begin
      kontrol("bekle_durum", durum, fault ? 3 : 0);
      return;
    end
    if (fault) begin
      m_gp = 0; m_ap = 0;
      repeat (4) begin
        @(negedge clk);
        kontrol("hata_gecerli", gecerli, 0);
        kontrol("hata_durum", durum, 3);
        kontrol("hata_bayrak", hata, 1);
        kontrol("hata_irtifa", irtifa, m_irt);
      end
      return;
    end
    fark = (m_g > m_a) ? m_g - m_a : m_a - m_g;
    ort  = (m_g + m_a) / 2;
    m_gp = 0; m_ap = 0;
    pulse = 0;
    if (fark <= 10) begin
      pen.push_back(ort);
      if (pen.size() > 4) void'(pen.pop_front());
      miss = 0;
      exp_d2 = 2;
      if (pen.size() == 4) begin
        sum = 0;
        foreach (pen[i]) sum += pen[i];
        m_irt = sum / 4;
        pulse = 1;
      end
    end else begin
      miss++;
      if (miss >= 3) begin fault = 1; exp_d2 = 3; end
      else exp_d2 = 0;
    end
    @(negedge clk);                       // after k+1
    kontrol("k1_durum", durum, 1);
    kontrol("k1_gecerli", gecerli, 0);
    if (coll) begin gs = 1; gnss = 16'(coll_g); end
    @(negedge clk);                       // after k+2
    if (coll) begin gs = 0; m_g = coll_g; m_gp = 1; end
    kontrol("k2_durum", durum, exp_d2);
    kontrol("k2_gecerli", gecerli, 0);
    kontrol("k2_hata", hata, fault);
    if (rst_mid) begin
      #1 rst_n = 0;
      #1;
      kontrol("rst_irtifa", irtifa, 0);
      kontrol("rst_gecerli", gecerli, 0);
      kontrol("rst_hata", hata, 0);
      kontrol("rst_durum", durum, 0);
      @(negedge clk);
      rst_n = 1;
      model_reset();
      return;
    end
    @(negedge clk);                       // after k+3
    kontrol("k3_gecerli", gecerli, pulse);
    kontrol("k3_irtifa", irtifa, m_irt);
    @(negedge clk);                       // after k+4
    kontrol("k4_gecerli", gecerli, 0);
    kontrol("k4_durum", durum, fault ? 3 : 0);
  endtask

  task automatic cift(input int g, input int a);
    surec(1, 1, g, a, 0, 0, 0);
  endtask

  initial begin
    int g, a, d;
    rst_n = 0; gs = 0; as = 0; gnss = 0; alt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    kontrol("reset_irtifa", irtifa, 0);
    kontrol("reset_gecerli", gecerli, 0);
    kontrol("reset_hata", hata, 0);
    kontrol("reset_durum", durum, 0);
    rst_n = 1;
    @(negedge clk);

    // Window fill, then rejection and window retention.
    cift(4, 6); cift(8, 16); cift(20, 26); cift(40, 46);
    cift(36, 20); cift(46, 52);

    // Boundaries: fark exactly MAX_FARK, full-scale pair.
    cift(50, 60);
    cift(16'hFFFF, 16'hFFFF);

    // Skew: gnss 5 cycles ahead of the altimeter.
    surec(1, 0, 100, 0, 0, 0, 0);
    repeat (4) begin
      @(negedge clk);
      kontrol("skew_bekle", durum, 0);
    end
    surec(0, 1, 0, 104, 0, 0, 0);

    // Double gnss strobe: newest sample pairs.
    surec(1, 0, 30, 0, 0, 0, 0);
    surec(1, 0, 32, 0, 0, 0, 0);
    surec(0, 1, 0, 34, 0, 0, 0);

    // Collision: gnss strobe on the flag-clearing edge survives.
    surec(1, 1, 200, 205, 1, 210, 0);
    surec(0, 1, 0, 212, 0, 0, 0);

    // Reset in ORTALA, then four fresh pairs before the first output.
    surec(1, 1, 300, 300, 0, 0, 1);
    cift(10, 12); cift(20, 22); cift(30, 32); cift(40, 42);

    // Fault latch and sticky behaviour.
    cift(56, 72); cift(10, 40); cift(0, 100);
    cift(45, 45); cift(45, 45);

    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
    kontrol("rst2_hata", hata, 0);
    kontrol("rst2_durum", durum, 0);

    // Randomised pairs with occasional skew.
    for (int i = 0; i < 60; i++) begin
      g = int'($urandom_range(0, 65535));
      d = int'($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 0) a = (g + d > 65535) ? g - d : g + d;
      else                           a = (g - d < 0) ? g + d : g - d;
      if ($urandom_range(0, 3) == 0) begin
        surec(1, 0, g, 0, 0, 0, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        surec(0, 1, 0, a, 0, 0, 0);
      end else begin
        cift(g, a);
      end
    end

    $display("test done: total=%0d bad=%0d", toplam_say, hatali);
    $finish;
  end

endmodule
